// File: rtl/bus_router.sv
// Routes the single memory_* master port to bram/print/clint with one outstanding
// transaction, forwarding only the selected slave's response and synthesising errors.
module bus_router #(
  parameter logic [31:0] BRAM_BASE  = 32'h0000_0000,
  parameter logic [31:0] BRAM_TOP   = 32'h0010_0000,
  parameter logic [31:0] PRINT_BASE = 32'h0100_0000,
  parameter logic [31:0] PRINT_TOP  = 32'h0100_0004,
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_TOP  = 32'h0200_C000,
  parameter logic [31:0] HOST_ADDR  = 32'h0000_1000,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clock,
  input  logic        reset,
  // master port
  input  logic        memory_valid,
  input  logic        memory_instr,
  input  logic [31:0] memory_addr,
  input  logic [31:0] memory_wdata,
  input  logic [3:0]  memory_wstrb,
  output logic [31:0] memory_rdata,
  output logic        memory_ready,
  output logic        memory_error,
  // bram slave
  output logic        bram_valid,
  output logic        bram_instr,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_wdata,
  output logic [3:0]  bram_wstrb,
  input  logic [31:0] bram_rdata,
  input  logic        bram_ready,
  // print slave
  output logic        print_valid,
  output logic        print_instr,
  output logic [31:0] print_addr,
  output logic [31:0] print_wdata,
  output logic [3:0]  print_wstrb,
  input  logic [31:0] print_rdata,
  input  logic        print_ready,
  // clint slave
  output logic        clint_valid,
  output logic        clint_instr,
  output logic [31:0] clint_addr,
  output logic [31:0] clint_wdata,
  output logic [3:0]  clint_wstrb,
  input  logic [31:0] clint_rdata,
  input  logic        clint_ready,
  // debug: current FSM state (0=IDLE, 1=BUSY, 2=ERR)
  output logic [1:0]  dbg_state_o
);

  // Handshake: memory_valid is sampled whenever the router can accept (IDLE, ERR, or
  // the completing BUSY cycle); the chosen *_valid is a one-cycle combinational pulse
  // in that same cycle, and memory_ready is a one-cycle strobe carrying rdata/error.

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TGT_NONE  = 2'd0,
    TGT_BRAM  = 2'd1,
    TGT_PRINT = 2'd2,
    TGT_CLINT = 2'd3
  } tgt_t;

  state_t        state_q, state_d;
  tgt_t          sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;

  tgt_t        dec_tgt;
  logic        sel_ready;
  logic [31:0] sel_rdata;
  logic        timeout_hit;
  logic        can_accept;
  logic        issue;

  always_comb begin
    dec_tgt = TGT_NONE;
    if (memory_addr >= CLINT_BASE && memory_addr < CLINT_TOP)
      dec_tgt = TGT_CLINT;
    else if (memory_addr >= PRINT_BASE && memory_addr < PRINT_TOP)
      dec_tgt = TGT_PRINT;
    else if (memory_addr >= BRAM_BASE && memory_addr < BRAM_TOP)
      dec_tgt = TGT_BRAM;
    else if (memory_addr == HOST_ADDR)
      dec_tgt = TGT_BRAM;
  end

  // Only the latched target's response is visible; all other readies are dropped.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = 32'h0;
    case (sel_q)
      TGT_BRAM:  begin sel_ready = bram_ready;  sel_rdata = bram_rdata;  end
      TGT_PRINT: begin sel_ready = print_ready; sel_rdata = print_rdata; end
      TGT_CLINT: begin sel_ready = clint_ready; sel_rdata = clint_rdata; end
      default:   begin sel_ready = 1'b0;        sel_rdata = 32'h0;       end
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    memory_ready = 1'b0;
    memory_error = 1'b0;
    memory_rdata = 32'h0;
    can_accept   = 1'b0;
    issue        = 1'b0;

    case (state_q)
      ST_IDLE: can_accept = 1'b1;
      ST_BUSY: begin
        if (sel_ready) begin
          memory_ready = 1'b1;
          memory_rdata = sel_rdata;
          can_accept   = 1'b1;
        end else if (timeout_hit) begin
          memory_ready = 1'b1;
          memory_error = 1'b1;
          can_accept   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ERR: begin
        memory_ready = 1'b1;
        memory_error = 1'b1;
        can_accept   = 1'b1;
      end
      default: can_accept = 1'b1;
    endcase

    if (can_accept) begin
      state_d = ST_IDLE;
      sel_d   = TGT_NONE;
      if (memory_valid && !reset) begin
        if (dec_tgt != TGT_NONE) begin
          issue   = 1'b1;
          state_d = ST_BUSY;
          sel_d   = dec_tgt;
          cnt_d   = '0;
        end else begin
          state_d = ST_ERR;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= TGT_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bram_valid  = issue && (dec_tgt == TGT_BRAM);
  assign print_valid = issue && (dec_tgt == TGT_PRINT);
  assign clint_valid = issue && (dec_tgt == TGT_CLINT);

  assign bram_addr  = memory_addr - BRAM_BASE;
  assign print_addr = memory_addr - PRINT_BASE;
  assign clint_addr = memory_addr - CLINT_BASE;

  assign bram_instr  = memory_instr;
  assign print_instr = memory_instr;
  assign clint_instr = memory_instr;
  assign bram_wdata  = memory_wdata;
  assign print_wdata = memory_wdata;
  assign clint_wdata = memory_wdata;
  assign bram_wstrb  = memory_wstrb;
  assign print_wstrb = memory_wstrb;
  assign clint_wstrb = memory_wstrb;

  assign dbg_state_o = state_q;

endmodule

// File: doc/bus_router.md
# bus_router

Sequential address router between the arbiter's single `memory_*` master port and the three SoC slaves (bram, print, clint). It replaces combinational decoding with a tracked one-outstanding transaction: it latches the decoded target on each request, forwards only that target's response, and synthesises an error response for unmapped addresses or slaves that never answer.

## Interface
- `BRAM_BASE`, 32'h0000_0000, bram window start (inclusive)
- `BRAM_TOP`, 32'h0010_0000, bram window end (exclusive)
- `PRINT_BASE`, 32'h0100_0000, print window start
- `PRINT_TOP`, 32'h0100_0004, print window end
- `CLINT_BASE`, 32'h0200_0000, clint window start
- `CLINT_TOP`, 32'h0200_C000, clint window end
- `HOST_ADDR`, 32'h0000_1000, single word routed to bram
- `TIMEOUT`, 1024, cycles to wait for a slave ready; 0 disables the timeout
- `reset`  in  1  asynchronous, active-high
- `clock`  in  1  rising-edge clock
- `memory_valid/instr/addr[31:0]/wdata[31:0]/wstrb[3:0]`  in  master request
- `memory_rdata`  out  32  response data
- `memory_ready`  out  1  one-cycle response strobe
- `memory_error`  out  1  high with `memory_ready` on an unmapped or timed-out access
- `bram_*`, `print_*`, `clint_*`: `valid`, `instr`, `addr`, `wdata`, `wstrb` out; `rdata[31:0]`, `ready` in

## Operation
- Decode priority: clint > print > bram > host. Each window match is `addr >= BASE && addr < TOP`. A `HOST_ADDR` match selects bram.
- Slave `addr` is `memory_addr - BASE`, using the selected window's base (`BRAM_BASE` for a host hit), computed modulo 2^32. `instr`, `wdata` and `wstrb` pass through to all slaves unchanged.
- States:
  - IDLE:
    - `memory_valid` with a mapped address: pulse the target `*_valid` in the same cycle, latch the target in `sel`, clear `cnt`, go to BUSY.
    - `memory_valid` with an unmapped address: no slave valid; go to ERR.
  - BUSY:
    - `sel` slave ready: drive `memory_ready=1` and `memory_rdata` = that slave's rdata, `memory_error=0`; go to IDLE.
    - Otherwise, when `TIMEOUT != 0` and `cnt == TIMEOUT-1`: drive `memory_ready=1`, `memory_rdata=0`, `memory_error=1`; go to IDLE.
    - Otherwise increment `cnt`. The width of `cnt` is $clog2(TIMEOUT+1) bits, and it saturates.
  - ERR: drive `memory_ready=1`, `memory_rdata=0`, `memory_error=1` for one cycle; go to IDLE.
- Readies from slaves not equal to `sel`, and any slave ready seen in IDLE or ERR (late responses after a timeout), are dropped. They never reach the master.
- A `memory_valid` in BUSY is ignored unless that cycle also completes the transaction. On completion it is decoded and accepted as if in IDLE: issued immediately, next state BUSY or ERR.
- A `memory_valid` in ERR is likewise accepted in the same cycle the error response is returned.
- Slave valids are strictly one-cycle pulses. Only one slave valid is ever high in a cycle.

## Timing
- Reset (async, any state): state=IDLE, `sel`=none, `cnt`=0.
  - All `*_valid`, `memory_ready` and `memory_error` are 0 while reset is high. `memory_rdata` is 0.
  - An in-flight transaction is abandoned; its later slave ready is dropped.
- Issue latency is 0: slave valid is combinational from `memory_valid` in IDLE.
- Mapped response: `memory_ready` appears in the same cycle as the slave ready, combinational pass-through. The minimum is 1 cycle after request, because slaves are registered.
- Unmapped response: exactly 1 cycle after request.
- Timeout response: in the TIMEOUT-th cycle after the issue cycle.
- Back-to-back: a completed response and a new issue can occur in the same cycle, giving one transaction per cycle against 1-cycle slaves.

## Test plan
- Mapped routing:
  - Read at 0x0000_0010; bram answers next cycle with 0xDEAD_BEEF.
  - Required: `bram_valid` pulses for 1 cycle with `bram_addr`=0x10, and the cycle after, `memory_ready=1`, `memory_rdata`=0xDEAD_BEEF, `memory_error=0`.
- Offset decode:
  - Write 0x41 with wstrb=4'h1 at 0x0100_0000. Required: only `print_valid` high, `print_addr`=0.
  - Access 0x0200_4000. Required: only `clint_valid` high, `clint_addr`=0x4000.
  - Access `HOST_ADDR`. Required: `bram_valid` high with `bram_addr`=0x1000.
- Unmapped:
  - Request at 0x3000_0000. Required: no slave valid, and 1 cycle later `memory_ready=1`, `memory_error=1`, `memory_rdata`=0.
- Timeout and stray ready:
  - With TIMEOUT=8, a bram request where bram stays silent. Required: error response exactly 8 cycles after issue.
  - A bram ready injected 2 cycles later. Required: does not produce `memory_ready`.
  - While BUSY on bram, print ready pulses. Required: ignored.
- Back-to-back:
  - Issue a new `memory_valid` to clint in the same cycle bram returns ready. Required: `memory_ready` for bram and `clint_valid` in the same cycle, and the clint response is delivered next.
- Reset mid-transaction:
  - Assert reset while BUSY. Required: outputs go to 0 immediately. After release, the stale slave ready yields no `memory_ready`, and a new request routes normally.
